// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op encodings,
// default latencies and a small decode helper.
package mult_div_unit_pkg;

    // MDctr op select encodings; 9..15 are treated as MD_NONE
    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8
    } md_op_e;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    // True for the ops that start a multi-cycle operation (mult/multu/div/divu)
    function automatic logic is_issue_op(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd4);
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit. Holds HI/LO, computes the result at issue
// into pending registers and commits them after a fixed latency, with busy
// high for the whole in-flight window. MDout is a combinational HI/LO read.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDctr,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDout
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic [31:0]      hi_r;
    logic [31:0]      lo_r;
    logic [31:0]      pend_hi_r;
    logic [31:0]      pend_lo_r;
    logic             pend_we_r;

    // Products: the low 64 bits of the product of sign-extended operands is the
    // signed product, so no signed types are needed.
    logic [63:0] smul_s;
    logic [63:0] umul_s;
    assign smul_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign umul_s = {32'd0, A} * {32'd0, B};

    // Division; a zero divisor is replaced by 1 to keep the arithmetic defined,
    // the result is then discarded because the write enable is dropped.
    logic        div_zero_s;
    logic [31:0] udivisor_s;
    logic [31:0] uq_s;
    logic [31:0] ur_s;
    logic [31:0] a_mag_s;
    logic [31:0] b_mag_s;
    logic [31:0] sq_mag_s;
    logic [31:0] sr_mag_s;
    logic [31:0] sq_s;
    logic [31:0] sr_s;

    assign div_zero_s = (B == 32'd0);
    assign udivisor_s = div_zero_s ? 32'd1 : B;
    assign uq_s       = A / udivisor_s;
    assign ur_s       = A % udivisor_s;

    // Signed divide via magnitudes: quotient truncates toward zero, remainder
    // takes the dividend's sign; 0x80000000 / -1 wraps to 0x80000000 naturally.
    assign a_mag_s  = A[31] ? (32'd0 - A) : A;
    assign b_mag_s  = div_zero_s ? 32'd1 : (B[31] ? (32'd0 - B) : B);
    assign sq_mag_s = a_mag_s / b_mag_s;
    assign sr_mag_s = a_mag_s % b_mag_s;
    assign sq_s     = (A[31] ^ B[31]) ? (32'd0 - sq_mag_s) : sq_mag_s;
    assign sr_s     = A[31] ? (32'd0 - sr_mag_s) : sr_mag_s;

    logic [31:0]      res_hi_s;
    logic [31:0]      res_lo_s;
    logic             res_we_s;
    logic [CNT_W-1:0] res_cycles_s;

    // Select the result, commit enable and latency for the op being issued
    always_comb begin
        res_hi_s     = 32'd0;
        res_lo_s     = 32'd0;
        res_we_s     = 1'b0;
        res_cycles_s = CNT_W'(MULT_CYCLES);
        case (MDctr)
            MD_MULT: begin
                res_hi_s = smul_s[63:32];
                res_lo_s = smul_s[31:0];
                res_we_s = 1'b1;
            end
            MD_MULTU: begin
                res_hi_s = umul_s[63:32];
                res_lo_s = umul_s[31:0];
                res_we_s = 1'b1;
            end
            MD_DIV: begin
                res_hi_s     = sr_s;
                res_lo_s     = sq_s;
                res_we_s     = !div_zero_s;
                res_cycles_s = CNT_W'(DIV_CYCLES);
            end
            MD_DIVU: begin
                res_hi_s     = ur_s;
                res_lo_s     = uq_s;
                res_we_s     = !div_zero_s;
                res_cycles_s = CNT_W'(DIV_CYCLES);
            end
            default: begin
                res_hi_s     = 32'd0;
                res_lo_s     = 32'd0;
                res_we_s     = 1'b0;
                res_cycles_s = CNT_W'(MULT_CYCLES);
            end
        endcase
    end

    // Issue, latency countdown, HI/LO commit and mthi/mtlo writes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r     <= '0;
            busy_r    <= 1'b0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            pend_hi_r <= 32'd0;
            pend_lo_r <= 32'd0;
            pend_we_r <= 1'b0;
        end else if (busy_r) begin
            // Everything except the countdown is ignored while in flight
            if (cnt_r == CNT_W'(1)) begin
                cnt_r  <= '0;
                busy_r <= 1'b0;
                if (pend_we_r) begin
                    hi_r <= pend_hi_r;
                    lo_r <= pend_lo_r;
                end else begin
                    hi_r <= hi_r;
                    lo_r <= lo_r;
                end
            end else begin
                cnt_r <= cnt_r - CNT_W'(1);
            end
        end else if (is_issue_op(MDctr)) begin
            pend_hi_r <= res_hi_s;
            pend_lo_r <= res_lo_s;
            pend_we_r <= res_we_s;
            cnt_r     <= res_cycles_s;
            busy_r    <= 1'b1;
        end else begin
            case (MDctr)
                MD_MTHI: hi_r <= A;
                MD_MTLO: lo_r <= A;
                default: begin
                    hi_r <= hi_r;
                    lo_r <= lo_r;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign HI   = hi_r;
    assign LO   = lo_r;

    // Combinational mfhi/mflo read path toward the EX/MEM result mux
    always_comb begin
        MDout = 32'd0;
        case (MDctr)
            MD_MFHI: MDout = hi_r;
            MD_MFLO: MDout = lo_r;
            default: MDout = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: an arithmetic reference model checked
// every cycle, plus directed vectors with hand-computed HI/LO values.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  MDctr;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDout;

    int checks = 0;
    int errors = 0;

    mult_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .B     (B),
        .MDctr (MDctr),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO),
        .MDout (MDout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    int          m_left = 0;
    logic [63:0] m_pend = 64'd0;
    bit          m_pend_we = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hi = 32'd0; m_lo = 32'd0; m_left = 0; m_pend_we = 1'b0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0 && m_pend_we) begin
                m_hi = m_pend[63:32];
                m_lo = m_pend[31:0];
            end
        end else begin
            longint sa, sb, sq, sr;
            sa = longint'($signed(A));
            sb = longint'($signed(B));
            case (MDctr)
                4'd1: begin m_pend = 64'(sa * sb); m_pend_we = 1'b1; m_left = 5; end
                4'd2: begin m_pend = {32'd0, A} * {32'd0, B}; m_pend_we = 1'b1; m_left = 5; end
                4'd3: begin
                    m_left = 10;
                    m_pend_we = (B != 32'd0);
                    if (B != 32'd0) begin
                        sq = sa / sb;
                        sr = sa % sb;
                        m_pend = {sr[31:0], sq[31:0]};
                    end
                end
                4'd4: begin
                    m_left = 10;
                    m_pend_we = (B != 32'd0);
                    if (B != 32'd0) m_pend = {A % B, A / B};
                end
                4'd5: m_hi = A;
                4'd6: m_lo = A;
                default: ;
            endcase
        end
    end

    // Per-cycle compare against the model, away from the rising edge
    always @(negedge clk) begin
        logic [31:0] exp_md;
        #1;
        if (!reset) begin
            exp_md = (MDctr == 4'd7) ? m_hi : ((MDctr == 4'd8) ? m_lo : 32'd0);
            check("model_busy", {31'd0, busy}, {31'd0, (m_left > 0)});
            check("model_hi", HI, m_hi);
            check("model_lo", LO, m_lo);
            check("model_mdout", MDout, exp_md);
        end
    end

    // ---------------- directed stimulus ----------------
    // Issue one op, then count busy cycles (bounded) and check final HI/LO.
    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_n,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        @(negedge clk);
        MDctr = op; A = a; B = b;
        @(negedge clk);
        MDctr = 4'd0; A = 32'd0; B = 32'd0;
        n = 0;
        #1;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
            #1;
        end
        check({name, "_busy_cycles"}, 32'(n), 32'(exp_n));
        check({name, "_hi"}, HI, exp_hi);
        check({name, "_lo"}, LO, exp_lo);
    endtask

    initial begin
        reset = 1'b1; A = 32'd0; B = 32'd0; MDctr = 4'd0;
        #12;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", HI, 32'd0);
        check("reset_lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("mult_neg", 4'd1, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
        run_op("multu_max", 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFE, 32'h00000001);
        run_op("div_neg", 4'd3, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu", 4'd4, 32'hFFFFFFF9, 32'd2, 10, 32'h00000001, 32'h7FFFFFFC);
        run_op("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);

        // Preload, then divide by zero: HI/LO must survive
        run_op("mthi", 4'd5, 32'h00001234, 32'd0, 0, 32'h00001234, 32'h80000000);
        run_op("mtlo", 4'd6, 32'h00005678, 32'd0, 0, 32'h00001234, 32'h00005678);
        run_op("div0", 4'd3, 32'd5, 32'd0, 10, 32'h00001234, 32'h00005678);
        run_op("divu0", 4'd4, 32'd9, 32'd0, 10, 32'h00001234, 32'h00005678);
        @(negedge clk);
        MDctr = 4'd7;
        #1 check("mfhi", MDout, 32'h00001234);
        @(negedge clk);
        MDctr = 4'd8;
        #1 check("mflo", MDout, 32'h00005678);
        @(negedge clk);
        MDctr = 4'd12;
        #1 check("op12_mdout", MDout, 32'd0);
        @(negedge clk);
        MDctr = 4'd0;

        // Ops while busy are ignored
        @(negedge clk);
        MDctr = 4'd1; A = 32'd2; B = 32'd3;
        @(negedge clk);
        MDctr = 4'd1; A = 32'd1; B = 32'd1;
        @(negedge clk);
        MDctr = 4'd5; A = 32'hDEADBEEF;
        @(negedge clk);
        MDctr = 4'd0; A = 32'd0; B = 32'd0;
        repeat (4) @(negedge clk);
        #1;
        check("ignore_busy_done", {31'd0, busy}, 32'd0);
        check("ignore_hi", HI, 32'd0);
        check("ignore_lo", LO, 32'd6);

        // Reset in the middle of a running div
        @(negedge clk);
        MDctr = 4'd4; A = 32'd100; B = 32'd7;
        @(negedge clk);
        MDctr = 4'd0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_hi", HI, 32'd0);
        check("midreset_lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        MDctr = 4'd8;
        #1 check("midreset_mflo", MDout, 32'd0);
        repeat (12) @(negedge clk);
        #1;
        check("midreset_no_commit", LO, 32'd0);
        MDctr = 4'd0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
EX-stage multiply/divide unit for the pipelined MIPS core. It sits beside the ALU and takes the same forwarded operands A/B. It holds the architectural HI/LO registers and models multi-cycle latency with a busy flag. Its read result (mfhi/mflo) feeds the EX/MEM result mux downstream, in parallel with the ALU output.

Parameters:
MULT_CYCLES, 5, cycles busy stays high after a mult/multu issue
DIV_CYCLES, 10, cycles busy stays high after a div/divu issue

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
A  input  32  forwarded rs operand
B  input  32  forwarded rt operand
MDctr  input  4  op select: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9-15 treated as none
busy  output  1  registered; high while an operation is in flight
HI  output  32  architectural HI register
LO  output  32  architectural LO register
MDout  output  32  combinational read: HI when MDctr=7, LO when MDctr=8, else 0

Interface decisions:
- One clock, clk; reset is asynchronous and active-high, named reset.

Behaviour:
- Reset (any time, including mid-operation): busy=0, HI=0, LO=0, counter=0; the pending result is discarded.
- Issue condition: MDctr in 1..4 sampled at a rising edge while busy=0.
- At the issue edge E:
  - compute the result into internal pending regs;
  - counter <= MULT_CYCLES or DIV_CYCLES;
  - busy <= 1.
- Each following edge, while counter>1: counter decrements.
- At the edge where counter==1:
  - HI/LO <= pending;
  - busy <= 0;
  - counter <= 0.
- Timing consequence: busy is high for exactly N cycles after E, and the new HI/LO are visible after edge E+N.
- mult: {HI,LO} = signed 64-bit product of A and B.
- multu: {HI,LO} = unsigned 64-bit product.
- div: LO = signed quotient (truncated toward zero), HI = remainder (sign of dividend).
- divu: unsigned quotient and remainder.
- Divide by zero (B=0): the op still runs the full DIV_CYCLES, then HI/LO are left unchanged.
- Signed div with 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (wraparound, no trap).
- mthi / mtlo with busy=0: HI<=A or LO<=A at that edge; no busy.
- Ops ignored while busy=1: any MDctr 1..6 is ignored (no state change). The pipeline guarantees this never happens by stalling.
- mfhi / mflo: purely combinational from the current HI/LO. They return stale data if issued while busy, so the pipeline stalls them too.
- Pipeline stall contract: the hazard unit stalls in ID when (ID instr is an MD-class op, MDctr 1..8) && (busy || EX MDctr in 1..4). That combinational term lives in the hazard unit, not here.
- Ops 9..15: no state change, MDout=0.

Decomposition:
- Shared package/header holds:
  - MDctr encodings MD_NONE..MD_MFLO;
  - default latencies MULT_CYCLES and DIV_CYCLES.
- No sub-module needed. A single always block handles counter/busy/HI/LO; the result computation is continuous assigns.

Test Plan:
- Reset during a running div, then release: busy=0, HI=LO=0 immediately (async); the next mflo returns 0.
- mult A=0xFFFFFFFE (-2), B=3 at edge E: busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu A=0xFFFFFFFF, B=0xFFFFFFFF: HI=0xFFFFFFFE, LO=0x00000001 after 5 cycles.
- div A=-7 (0xFFFFFFF9), B=2: after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu with the same operands gives LO=0x7FFFFFFC, HI=1.
- Preload with mthi 0x1234 then mtlo 0x5678, then div by B=0: busy for 10 cycles, then HI=0x1234, LO=0x5678 unchanged; MDctr=7 gives MDout=0x1234 and MDctr=8 gives MDout=0x5678.
- Issue mult, then MDctr=1 (A=1, B=1) and MDctr=5 while busy: both ignored; the final HI/LO come from the first mult only.
